min_max_scan: RTL and testbench

MIN_MAX_SCAN -- requirements
Module: min_max_scan

---
 rtl/min_max_scan.sv | 163 ++++++++++++++++
 tb/tb_min_max_scan.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/min_max_scan.sv
// min_max_scan: snapshots N_CH unsigned channel values on start, then walks
// them one channel per clock to find the minimum or maximum. Reports the
// winning channel index, its value and the ASCII digit of the index.
//
// Handshake: start is a request that is honoured only while busy is low.
// On that edge the inputs are captured and busy rises. Requests made while
// busy is high are dropped, not queued. Results become valid on the single
// cycle where done is high, and they hold until the next completion.
// Because the FSM is already idle on the done cycle, a start in that cycle
// is accepted.
module min_max_scan #(
    parameter int N_CH = 4,
    parameter int W    = 3,
    localparam int IW  = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH*W-1:0] data_in,
    input  logic            start,
    input  logic            max_sel,
    output logic            busy,
    output logic            done,
    output logic [IW-1:0]   result_index,
    output logic [W-1:0]    result_value,
    output logic [7:0]      result_ascii,
    output logic            o_dbg_state
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    // Registered state
    state_t              r_state;
    logic [N_CH*W-1:0]   r_snap;
    logic                r_max_sel;
    logic [W-1:0]        r_best_val;
    logic [IW-1:0]       r_best_idx;
    logic [IW-1:0]       r_cnt;
    logic                r_done;
    logic [IW-1:0]       r_res_idx;
    logic [W-1:0]        r_res_val;
    logic [7:0]          r_res_ascii;

    // Next-state values
    state_t              w_nxt_state;
    logic [N_CH*W-1:0]   w_nxt_snap;
    logic                w_nxt_max_sel;
    logic [W-1:0]        w_nxt_best_val;
    logic [IW-1:0]       w_nxt_best_idx;
    logic [IW-1:0]       w_nxt_cnt;
    logic                w_nxt_done;
    logic [IW-1:0]       w_nxt_res_idx;
    logic [W-1:0]        w_nxt_res_val;
    logic [7:0]          w_nxt_res_ascii;

    // Datapath helpers
    logic [W-1:0]        w_chans [N_CH];
    logic [W-1:0]        w_cur;
    logic                w_better;
    logic [W-1:0]        w_upd_val;
    logic [IW-1:0]       w_upd_idx;
    logic                w_last;

    // Unpack the snapshot into per-channel values
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_chans[i] = r_snap[i*W +: W];
        end
    end

    // Candidate channel compare; strict so the lower index keeps a tie
    always_comb begin
        w_cur     = w_chans[r_cnt];
        w_better  = r_max_sel ? (w_cur > r_best_val) : (w_cur < r_best_val);
        w_upd_val = w_better ? w_cur : r_best_val;
        w_upd_idx = w_better ? r_cnt : r_best_idx;
        w_last    = (r_cnt == IW'(N_CH - 1));
    end

    // Next-state and datapath update logic
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_snap      = r_snap;
        w_nxt_max_sel   = r_max_sel;
        w_nxt_best_val  = r_best_val;
        w_nxt_best_idx  = r_best_idx;
        w_nxt_cnt       = r_cnt;
        w_nxt_done      = 1'b0;
        w_nxt_res_idx   = r_res_idx;
        w_nxt_res_val   = r_res_val;
        w_nxt_res_ascii = r_res_ascii;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nxt_snap     = data_in;
                    w_nxt_max_sel  = max_sel;
                    w_nxt_best_val = data_in[W-1:0];
                    w_nxt_best_idx = '0;
                    w_nxt_cnt      = IW'(1);
                    w_nxt_state    = S_SCAN;
                end
            end
            S_SCAN: begin
                w_nxt_best_val = w_upd_val;
                w_nxt_best_idx = w_upd_idx;
                if (w_last) begin
                    w_nxt_res_idx   = w_upd_idx;
                    w_nxt_res_val   = w_upd_val;
                    w_nxt_res_ascii = 8'h30 + 8'(w_upd_idx);
                    w_nxt_done      = 1'b1;
                    w_nxt_cnt       = '0;
                    w_nxt_state     = S_IDLE;
                end else begin
                    w_nxt_cnt = r_cnt + IW'(1);
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_snap      <= '0;
            r_max_sel   <= 1'b0;
            r_best_val  <= '0;
            r_best_idx  <= '0;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_res_idx   <= '0;
            r_res_val   <= '0;
            r_res_ascii <= 8'h00;
        end else begin
            r_state     <= w_nxt_state;
            r_snap      <= w_nxt_snap;
            r_max_sel   <= w_nxt_max_sel;
            r_best_val  <= w_nxt_best_val;
            r_best_idx  <= w_nxt_best_idx;
            r_cnt       <= w_nxt_cnt;
            r_done      <= w_nxt_done;
            r_res_idx   <= w_nxt_res_idx;
            r_res_val   <= w_nxt_res_val;
            r_res_ascii <= w_nxt_res_ascii;
        end
    end

    // Output mapping
    always_comb begin
        busy         = (r_state == S_SCAN);
        done         = r_done;
        result_index = r_res_idx;
        result_value = r_res_val;
        result_ascii = r_res_ascii;
        o_dbg_state  = (r_state == S_SCAN);
    end

endmodule

// File: tb/tb_min_max_scan.sv
// Directed bench for min_max_scan with N_CH=4, W=3: a table of scans with
// hand-computed winners plus sequences for snapshot, busy re-start,
// back-to-back start and mid-scan reset.
module tb_min_max_scan;

    localparam int N_CH = 4;
    localparam int W    = 3;
    localparam int IW   = 2;

    logic            clk;
    logic            rst;
    logic [N_CH*W-1:0] data_in;
    logic            start;
    logic            max_sel;
    logic            busy;
    logic            done;
    logic [IW-1:0]   result_index;
    logic [W-1:0]    result_value;
    logic [7:0]      result_ascii;
    logic            dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    min_max_scan #(.N_CH(N_CH), .W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .start        (start),
        .max_sel      (max_sel),
        .busy         (busy),
        .done         (done),
        .result_index (result_index),
        .result_value (result_value),
        .result_ascii (result_ascii),
        .o_dbg_state  (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        msel;
        logic [11:0] data;
        logic [1:0]  idx;
        logic [2:0]  val;
        string       name;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [11:0] pk(int c0, int c1, int c2, int c3);
        return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Drive a start pulse; returns at the negedge after the start edge
    task automatic issue_start(input logic msel, input logic [11:0] data);
        data_in = data;
        max_sel = msel;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // From the negedge after a start edge, wait for done (bounded)
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 8) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    // Full scan with latency, busy, result, pulse width and hold checks
    task automatic run_scan(input logic msel, input logic [11:0] data,
                            input logic [1:0] eidx, input logic [2:0] evalue,
                            input string name, input bit scramble);
        int lat, bc;
        issue_start(msel, data);
        if (scramble) begin
            data_in = '0;
            max_sel = ~msel;
        end
        wait_done(lat, bc);
        chk({name, " latency"}, lat, 3);
        chk({name, " busy_cycles"}, bc, 3);
        chk({name, " index"}, int'(result_index), int'(eidx));
        chk({name, " value"}, int'(result_value), int'(evalue));
        chk({name, " ascii"}, int'(result_ascii), 32'h30 + int'(eidx));
        chk({name, " busy_at_done"}, int'(busy), 0);
        @(negedge clk);
        chk({name, " done_one_cycle"}, int'(done), 0);
        @(negedge clk);
        chk({name, " index_hold"}, int'(result_index), int'(eidx));
        chk({name, " value_hold"}, int'(result_value), int'(evalue));
    endtask

    initial begin
        int lat, bc, pulses;

        vecs[0] = '{1'b0, pk(5,2,6,7), 2'd1, 3'd2, "min_5267"};
        vecs[1] = '{1'b0, pk(3,3,3,3), 2'd0, 3'd3, "min_all3"};
        vecs[2] = '{1'b1, pk(1,7,7,0), 2'd1, 3'd7, "max_tie7"};
        vecs[3] = '{1'b1, pk(0,0,0,0), 2'd0, 3'd0, "max_all0"};
        vecs[4] = '{1'b0, pk(7,6,5,4), 2'd3, 3'd4, "min_desc"};
        vecs[5] = '{1'b1, pk(2,3,6,1), 2'd2, 3'd6, "max_mid"};
        vecs[6] = '{1'b0, pk(0,7,0,0), 2'd0, 3'd0, "min_tie0"};
        vecs[7] = '{1'b1, pk(6,6,5,7), 2'd3, 3'd7, "max_last"};

        // Reset
        rst = 1'b1; start = 1'b0; max_sel = 1'b0; data_in = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset index", int'(result_index), 0);
        chk("reset value", int'(result_value), 0);
        chk("reset ascii", int'(result_ascii), 0);
        rst = 1'b0;

        // Table-driven scans
        for (int i = 0; i < 8; i++) begin
            run_scan(vecs[i].msel, vecs[i].data, vecs[i].idx, vecs[i].val,
                     vecs[i].name, 1'b0);
        end

        // Snapshot: inputs changed after start must not matter
        run_scan(1'b0, pk(4,4,4,1), 2'd3, 3'd1, "snapshot", 1'b1);

        // Start re-pulsed while busy is ignored
        issue_start(1'b0, pk(5,2,6,7));
        data_in = pk(0,0,0,0); max_sel = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        chk("busy_restart pulses", pulses, 1);
        chk("busy_restart index", int'(result_index), 1);
        chk("busy_restart value", int'(result_value), 2);
        chk("busy_restart busy", int'(busy), 0);

        // Back-to-back: start again on the done cycle
        issue_start(1'b0, pk(7,6,5,4));
        wait_done(lat, bc);
        chk("b2b first latency", lat, 3);
        chk("b2b first index", int'(result_index), 3);
        issue_start(1'b1, pk(1,7,7,0));
        chk("b2b second busy", int'(busy), 1);
        wait_done(lat, bc);
        chk("b2b second latency", lat, 3);
        chk("b2b second index", int'(result_index), 1);
        chk("b2b second value", int'(result_value), 7);
        chk("b2b second ascii", int'(result_ascii), 32'h31);
        @(negedge clk);

        // Reset on the second SCAN edge aborts the scan
        issue_start(1'b0, pk(5,2,6,7));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", int'(busy), 0);
        chk("abort index", int'(result_index), 0);
        chk("abort value", int'(result_value), 0);
        chk("abort ascii", int'(result_ascii), 0);
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        chk("abort done_pulses", pulses, 0);

        // Start right after reset release
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_scan(1'b1, pk(2,3,6,1), 2'd2, 3'd6, "post_reset", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
